interp_serializer: RTL
======================

# interp_serializer

Downstream stage of `interp_filt`: accepts the 16-bit interpolated word `Z` through a valid/ready handshake, buffers words in a small FIFO, and streams each word out MSB-first, one bit per `DIV` clock cycles, as a continuous bitstream for the 1-bit output path. Back-to-back frames are emitted with no gap. An empty FIFO at a frame boundary is reported as an underrun.

## Interface
- `DIV`, default 2: clock cycles each output bit is held (≥1).
- `DEPTH`, default 4: FIFO depth in words (power of two, ≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `z_data` in 16: interpolated word (`Z` of `interp_filt`).
- `z_valid` in 1: `z_data` is valid this cycle.
- `z_ready` out 1: FIFO can accept a word this cycle.
- `bit_out` out 1: serial data, MSB of each word first.
- `bit_valid` out 1: `bit_out` carries stream data.
- `frame_start` out 1: pulse on the first cycle of bit 15 of each word.
- `underrun` out 1: one-cycle pulse when a frame ends and the FIFO is empty.

## Operation
- Reset values: `z_ready`=1; `bit_out`=0, `bit_valid`=0, `frame_start`=0, `underrun`=0. FIFO is emptied. State is IDLE and all counters are 0.
- Write happens when `z_valid && z_ready`. `z_ready` = !full and is registered from the FIFO count. It does not anticipate a same-cycle pop. No bypass: a word written into an empty FIFO is first visible to the reader on the next cycle.
- State IDLE:
  - If the FIFO is non-empty, pop into the 16-bit shift register, set `bit_cnt`=15 and `div_cnt`=0, and go to SHIFT.
  - Otherwise stay in IDLE.
- State SHIFT:
  - `bit_out` = shreg[15]; `bit_valid`=1.
  - `div_cnt` counts 0..DIV-1. On wrap, shift left and decrement `bit_cnt`.
  - At the last cycle of bit 0, if the FIFO is non-empty, pop and reload in the same edge and stay in SHIFT (gapless).
  - Otherwise go to IDLE and pulse `underrun` in the first IDLE cycle.
- `frame_start` = SHIFT && `bit_cnt`==15 && `div_cnt`==0.
- In IDLE, `bit_out` and `bit_valid` are 0.
- A simultaneous push and pop in one cycle is legal. The count is unchanged.
- Reset asserted mid-frame: the frame is dropped, all FIFO contents are discarded, and no `underrun` pulse is generated.
- Widths: `div_cnt` is $clog2(DIV) bits (1 bit minimum). `bit_cnt` is 4 bits. The FIFO count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

## Timing
- Latency: word accepted at cycle N → popped at the end of N+1 → first bit (`frame_start`) on cycle N+2.
- Each frame lasts 16×DIV cycles. Frames repeat with zero idle cycles while the FIFO is non-empty.
- `underrun` occurs on cycle (last bit cycle + 1). It is never asserted before the first frame.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `interp_pkg`:
  - `Z_W`=16, `A_W`=4.
  - `ser_state_t` enum {IDLE, SHIFT}.
- Sub-module `interp_fifo`:
  - Synchronous FIFO (DEPTH×Z_W), with push/pop/full/empty/count.
  - Reset is synchronous.
- The top level holds the FSM, the shift register and the counters.

## Test plan
- Reset: hold `rst` for 3 cycles, then check `z_ready`=1, all other outputs 0, and no activity for 10 idle cycles.
- Single word, DIV=2: write 16'hA5C3 at cycle 0. Expect:
  - `frame_start` at cycle 2.
  - `bit_out` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each bit held 2 cycles, over cycles 2–33.
  - `underrun` at cycle 34, then `bit_valid`=0.
- Backpressure, DIV=2, DEPTH=4: offer six words on cycles 0–5. Expect:
  - `z_ready`=0 at cycle 5.
  - Word 6 is accepted at cycle 34.
  - All six frames are contiguous, with `frame_start` every 32 cycles.
  - No loss or duplication, and `underrun` only after frame 6.
- Reset mid-frame: assert `rst` at frame cycle 10 with 2 words queued. Expect all outputs 0 and `z_ready`=1 next cycle, no `underrun` pulse, and a subsequent write streams normally.
- DIV=1: write 16'h8001 and 16'hFFFF on consecutive cycles. Expect 32 consecutive valid bits: 1, then fourteen 0s, then 1, then sixteen 1s. `frame_start` fires at cycles 2 and 18.
- Sweep: write the outputs of `interp_filt` for A=0..15 at random gaps. The scoreboard checks that the bitstream matches the word order and that `underrun` fires exactly when the FIFO empties at a frame boundary.

Source files
------------

// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared types and widths for the interpolator output path
package interp_pkg;
  localparam int Z_W = 16;
  localparam int A_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/interp_fifo.sv
// rtl/interp_fifo.sv - synchronous word FIFO with registered full/empty flags
module interp_fifo
  import interp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic [Z_W-1:0] i_wdata,
  input  logic           i_pop,
  output logic [Z_W-1:0] o_rdata,
  output logic           o_full,
  output logic           o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [Z_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_full;
  logic           r_empty;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count_nxt;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Flags are registered from the next count so they never see a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end
endmodule

// File: rtl/interp_serializer.sv
// rtl/interp_serializer.sv - buffers interpolated words and streams them MSB-first
module interp_serializer
  import interp_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Z_W-1:0] z_data,
  input  logic           z_valid,
  output logic           z_ready,
  output logic           bit_out,
  output logic           bit_valid,
  output logic           frame_start,
  output logic           underrun
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  ser_state_t     r_state;
  logic [Z_W-1:0] r_shreg;
  logic [A_W-1:0] r_bit_cnt;
  logic [DW-1:0]  r_div_cnt;
  logic           r_bit_valid;
  logic           r_frame_start;
  logic           r_underrun;

  logic [Z_W-1:0] w_rd_data;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_div_wrap;
  logic           w_frame_end;

  assign w_push      = z_valid && !w_full;
  assign w_div_wrap  = (r_div_cnt == DW'(DIV - 1));
  assign w_frame_end = (r_state == SHIFT) && w_div_wrap && (r_bit_cnt == '0);
  assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);

  interp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_wdata(z_data),
    .i_pop  (w_pop),
    .o_rdata(w_rd_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // The shift register is cleared in IDLE, so its MSB doubles as the idle-low bit_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_div_cnt     <= '0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (w_pop) begin
        r_state       <= SHIFT;
        r_shreg       <= w_rd_data;
        r_bit_cnt     <= A_W'(Z_W - 1);
        r_div_cnt     <= '0;
        r_bit_valid   <= 1'b1;
        r_frame_start <= 1'b1;
      end else if (r_state == SHIFT) begin
        if (w_frame_end) begin
          r_state     <= IDLE;
          r_shreg     <= '0;
          r_div_cnt   <= '0;
          r_bit_valid <= 1'b0;
          r_underrun  <= 1'b1;
        end else if (w_div_wrap) begin
          r_shreg   <= {r_shreg[Z_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - 1'b1;
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
    end
  end

  assign z_ready     = !w_full;
  assign bit_out     = r_shreg[Z_W-1];
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
endmodule
